// File: rtl/cla_seq_adder.sv
// Sequential WIDTH-bit add/subtract built around one 4-bit carry look-ahead slice, one nibble per clock, LSB first.
// Optional zero/neg/ovf flags are built only when CLA_SEQ_FLAGS_EN is defined; otherwise they read 0.
module cla_seq_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);
  localparam int N  = WIDTH / 4;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic            carry;
  logic [CW-1:0]   cnt;

  logic [3:0] na, nb, g, p, sum;
  logic [4:0] c;
  logic       last;

  always_comb begin
    na = ra[4*cnt +: 4];
    nb = rb[4*cnt +: 4];
    g  = na & nb;
    p  = na ^ nb;
    c[0] = carry;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    sum  = p ^ c[3:0];
    last = (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      co    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef CLA_SEQ_FLAGS_EN
      zero  <= 1'b0;
      neg   <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // Subtract is a + ~b + 1, so the carry register seeds the +1.
            ra    <= a;
            rb    <= op ? ~b : b;
            carry <= op ? 1'b1 : ci;
            cnt   <= '0;
            s     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          s[4*cnt +: 4] <= sum;
          carry         <= c[4];
          if (last) begin
            co    <= c[4];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
`ifdef CLA_SEQ_FLAGS_EN
            // Flags see the final result: top nibble from the slice, rest already registered.
            zero  <= ({sum, s[WIDTH-5:0]} == '0);
            neg   <= sum[3];
            ovf   <= c[3] ^ c[4];
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef CLA_SEQ_FLAGS_EN
  assign zero = 1'b0;
  assign neg  = 1'b0;
  assign ovf  = 1'b0;
`endif

endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Multi-cycle WIDTH-bit adder/subtractor controller that reuses a single 4-bit carry look-ahead slice. It processes one nibble per clock, least significant first, carrying between nibbles through a registered carry. It sits in the ALU as a low-area alternative to a full-width CLA chain and exposes a start/busy/done handshake to the issuing control logic.

## Interface
- WIDTH, 32: operand width in bits; must be a multiple of 4 and at least 8; N = WIDTH/4 nibble steps.
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  in  1  request; accepted only in IDLE or DONE.
- op  in  1  0 = add (a + b + ci), 1 = subtract (a − b; ci ignored).
- a  in  WIDTH  operand A, latched on accept.
- b  in  WIDTH  operand B, latched on accept.
- ci  in  1  carry-in for add, latched on accept.
- s  out  WIDTH  result; holds the last result until the next accepted start.
- co  out  1  carry-out of MSB nibble.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse in DONE; result valid.
- zero  out  1  s == 0 (flag feature).
- neg  out  1  s[WIDTH-1] (flag feature).
- ovf  out  1  signed overflow (flag feature).

## Operation
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- On reset, all outputs are 0, the internal registers and nibble counter cnt are cleared, and the carry register is cleared.
- **IDLE, start=1:**
  - Latch a into ra.
  - Latch b into rb, or ~b when op=1.
  - Load carry with ci, or 1 when op=1.
  - Set cnt = 0, clear s, and go to RUN.
- **RUN, each cycle:**
  - The slice computes ra[4cnt+3:4cnt] + rb[4cnt+3:4cnt] + carry.
  - The 4-bit sum is written to s[4cnt+3:4cnt] and the slice carry-out goes to carry.
  - If cnt == N−1: co <= slice carry-out, ovf <= slice c3 XOR slice carry-out, and go to DONE. Otherwise cnt <= cnt+1.
- **DONE:**
  - done = 1 for exactly one cycle.
  - start=1 is accepted with the same actions as IDLE (back-to-back), and the next state is RUN. Otherwise the next state is IDLE.
- **start while in RUN:** ignored. Latched operands and progress are unaffected. No queueing.
- **Arithmetic:**
  - Results are modulo 2^WIDTH.
  - For subtract, co = 1 means no borrow (a ≥ b unsigned).
  - zero and neg are derived from the final s and updated on the same edge as co.
- **Reset during RUN or DONE:** the operation is abandoned. The next cycle shows the reset values, and no done pulse is generated.

## Timing
- Latency: start sampled at edge E0; nibble k is written at edge E(k+1); DONE is entered at edge EN.
- done is high in the cycle after EN. For WIDTH=32, done is high in the 8th cycle after the accepting edge.
- busy is high from edge E1 through edge EN (exactly N cycles), and is low in DONE and IDLE.
- s, co and flags are stable from DONE until the next accepting edge.
- The partial s is visible during RUN and must not be used by consumers.
- Throughput with back-to-back starts is one result per N+1 cycles.
- The slice is purely combinational between registers. The critical path is operand mux → slice → s/carry registers.

## Configuration
- CLA_SEQ_FLAGS_EN:
  - Defined: zero, neg and ovf are computed and registered as above.
  - Undefined: zero, neg and ovf are tied to constant 0, and the flag registers and the c3 tap are removed.
  - s, co, busy and done behave identically either way.

## Test plan
- **Unsigned wrap (add):** add a=0xFFFFFFFF, b=0x00000001, ci=0 → done pulse 8 cycles after start. s=0x00000000, co=1, zero=1, ovf=0.
- **Subtract with borrow:** sub a=0x00000005, b=0x00000007 → s=0xFFFFFFFE, co=0, neg=1, zero=0, ovf=0.
- **Signed overflow:** add a=0x7FFFFFFF, b=0x00000001, ci=0 → s=0x80000000, ovf=1, neg=1, co=0. With CLA_SEQ_FLAGS_EN undefined, s and co are the same and all flags are 0.
- **Start while busy:** start add a=0x12345678 + b=0x11111111. Pulse start with new operands at RUN cycle 3 → the second start is ignored. s=0x23456789, exactly one done pulse, busy high for exactly 8 cycles.
- **Reset mid-run:** reset_n=0 at RUN cycle 4 → next cycle s=0, co=0, busy=0, done=0, state IDLE. A later add 0x00000001 + 0x00000001 gives s=0x00000002.
- **Back-to-back:** in the DONE cycle of 0x00000010+0x00000020 (s=0x00000030), assert start with 0x00000003−0x00000003 → busy rises next cycle. The second done pulse comes 9 cycles after the first, with s=0x00000000, co=1, zero=1.
